// File: rtl/imm_gen_pipe.sv
// RISC-V immediate decoder feeding a DEPTH-entry output FIFO (valid/ready on both sides).
// Define IMM_GEN_STATS_EN to add the saturating unknown-opcode counter on port unknown_cnt.
module imm_gen_pipe #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out,
    output logic [2:0]      fmt,
    output logic            unknown
`ifdef IMM_GEN_STATS_EN
    ,
    output logic [15:0]     unknown_cnt
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } fmt_e;

    logic [31:0]     dec_imm32;
    fmt_e            dec_fmt;
    logic            dec_unknown;
    logic [XLEN-1:0] dec_imm;

    logic [XLEN-1:0] imm_q [DEPTH];
    logic [XLEN-1:0] imm_d [DEPTH];
    logic [2:0]      fmt_q [DEPTH];
    logic [2:0]      fmt_d [DEPTH];
    logic            unk_q [DEPTH];
    logic            unk_d [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic accept;
    logic pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Every immediate format fits in 32 bits once sign-extended, so decode there and widen.
    always_comb begin
        dec_imm32   = '0;
        dec_fmt     = FMT_NONE;
        dec_unknown = 1'b0;
        case (in[6:0])
            7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111: begin
                dec_fmt   = FMT_I;
                dec_imm32 = {{20{in[31]}}, in[31:20]};
            end
            7'b0100011: begin
                dec_fmt   = FMT_S;
                dec_imm32 = {{20{in[31]}}, in[31:25], in[11:7]};
            end
            7'b1100011: begin
                dec_fmt   = FMT_B;
                dec_imm32 = {{19{in[31]}}, in[31], in[7], in[30:25], in[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec_fmt   = FMT_U;
                dec_imm32 = {in[31:12], 12'b0};
            end
            7'b1101111: begin
                dec_fmt   = FMT_J;
                dec_imm32 = {{11{in[31]}}, in[31], in[19:12], in[20], in[30:21], 1'b0};
            end
            default: begin
                dec_unknown = 1'b1;
            end
        endcase
    end

    if (XLEN > 32) begin : g_ext
        assign dec_imm = {{(XLEN-32){dec_imm32[31]}}, dec_imm32};
    end else begin : g_trunc
        assign dec_imm = dec_imm32[XLEN-1:0];
    end

    // Ready depends only on the registered count, never on out_ready.
    assign in_ready  = (count_q < CNT_FULL);
    assign out_valid = (count_q != '0);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        imm_d    = imm_q;
        fmt_d    = fmt_q;
        unk_d    = unk_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (accept) begin
            imm_d[wr_ptr_q] = dec_imm;
            fmt_d[wr_ptr_q] = dec_fmt;
            unk_d[wr_ptr_q] = dec_unknown;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({accept, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imm_q    <= '{default: '0};
            fmt_q    <= '{default: '0};
            unk_q    <= '{default: 1'b0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            imm_q    <= imm_d;
            fmt_q    <= fmt_d;
            unk_q    <= unk_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Popped slots keep stale data, so the head is forced to zero whenever the FIFO is empty.
    assign out     = out_valid ? imm_q[rd_ptr_q] : '0;
    assign fmt     = out_valid ? fmt_q[rd_ptr_q] : 3'd0;
    assign unknown = out_valid ? unk_q[rd_ptr_q] : 1'b0;

`ifdef IMM_GEN_STATS_EN
    logic [15:0] unknown_cnt_q, unknown_cnt_d;

    always_comb begin
        unknown_cnt_d = unknown_cnt_q;
        if (accept && dec_unknown && (unknown_cnt_q != 16'hFFFF)) begin
            unknown_cnt_d = unknown_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            unknown_cnt_q <= '0;
        end else begin
            unknown_cnt_q <= unknown_cnt_d;
        end
    end

    assign unknown_cnt = unknown_cnt_q;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=64 and XLEN=32 instances share stimulus and are checked each cycle
// against a queue-based model with an arithmetic reference decoder.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_w = '0;
    logic        out_ready = 1'b0;

    logic        in_ready64, out_valid64, unk64;
    logic [63:0] out64;
    logic [2:0]  fmt64;
    logic        in_ready32, out_valid32, unk32;
    logic [31:0] out32;
    logic [2:0]  fmt32;
`ifdef IMM_GEN_STATS_EN
    logic [15:0] ucnt64, ucnt32;
`endif

    int errors = 0;
    int checks = 0;
    int n_pops = 0;
    logic [31:0] mq[$];
    int m_unk = 0;

    logic [6:0] ops [10] = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(64), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64), .in(in_w),
        .out_valid(out_valid64), .out_ready(out_ready), .out(out64), .fmt(fmt64), .unknown(unk64)
`ifdef IMM_GEN_STATS_EN
        , .unknown_cnt(ucnt64)
`endif
    );

    imm_gen_pipe #(.XLEN(32), .DEPTH(2)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32), .in(in_w),
        .out_valid(out_valid32), .out_ready(out_ready), .out(out32), .fmt(fmt32), .unknown(unk32)
`ifdef IMM_GEN_STATS_EN
        , .unknown_cnt(ucnt32)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decoder: gather the raw immediate field, then sign-correct it arithmetically.
    function automatic void ref_dec(input logic [31:0] w, output logic [63:0] imm,
                                    output logic [2:0] f, output logic u);
        longint raw;
        int     n;
        raw = 0; n = 0; f = 3'd0; u = 1'b0;
        case (w[6:0])
            7'h03, 7'h13, 7'h1B, 7'h67: begin f = 3'd1; n = 12; raw = w[31:20]; end
            7'h23: begin f = 3'd2; n = 12; raw = {w[31:25], w[11:7]}; end
            7'h63: begin f = 3'd3; n = 13; raw = {w[31], w[7], w[30:25], w[11:8], 1'b0}; end
            7'h37, 7'h17: begin f = 3'd4; n = 32; raw = {w[31:12], 12'b0}; end
            7'h6F: begin f = 3'd5; n = 21; raw = {w[31], w[19:12], w[20], w[30:21], 1'b0}; end
            default: u = 1'b1;
        endcase
        if (n > 0 && raw[n-1]) raw = raw - (longint'(1) << n);
        imm = raw;
    endfunction

    always @(posedge clk or posedge rst) begin
        bit acc, pp;
        logic [63:0] ti; logic [2:0] tf; logic tu;
        if (rst) begin
            mq.delete();
            m_unk = 0;
        end else begin
            acc = in_valid && (mq.size() < 2);
            pp  = out_ready && (mq.size() > 0);
            if (pp) begin
                void'(mq.pop_front());
                n_pops++;
            end
            if (acc) begin
                mq.push_back(in_w);
                ref_dec(in_w, ti, tf, tu);
                if (tu && m_unk < 65535) m_unk++;
            end
        end
    end

    always @(negedge clk) begin
        logic [63:0] e_imm; logic [2:0] e_f; logic e_u;
        if (mq.size() > 0) ref_dec(mq[0], e_imm, e_f, e_u);
        else begin e_imm = '0; e_f = '0; e_u = 1'b0; end
        chk("in_ready64", in_ready64, mq.size() < 2);
        chk("in_ready32", in_ready32, mq.size() < 2);
        chk("out_valid64", out_valid64, mq.size() > 0);
        chk("out_valid32", out_valid32, mq.size() > 0);
        chk("out64", out64, e_imm);
        chk("out32", out32, e_imm[31:0]);
        chk("fmt64", fmt64, e_f);
        chk("fmt32", fmt32, e_f);
        chk("unknown64", unk64, e_u);
        chk("unknown32", unk32, e_u);
`ifdef IMM_GEN_STATS_EN
        chk("unknown_cnt64", ucnt64, m_unk);
        chk("unknown_cnt32", ucnt32, m_unk);
`endif
    end

    // Accept one word into the empty FIFO, check the head right after the edge, then drain it.
    task automatic send_one(input logic [31:0] w, input logic [63:0] e64, input logic [2:0] ef,
                            input logic eu, input logic [31:0] e32);
        @(negedge clk);
        in_valid = 1'b1; in_w = w; out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("lat_out_valid", out_valid64, 1'b1);
        chk("lit_out64", out64, e64);
        chk("lit_fmt", fmt64, ef);
        chk("lit_unknown", unk64, eu);
        chk("lit_out32", out32, e32);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [63:0] mi; logic [2:0] mf; logic mu;
        logic [31:0] w;
        int r, cyc, start_pops;

        ref_dec(32'hFE000EE3, mi, mf, mu);
        chk("model_beq", mi, 64'hFFFF_FFFF_FFFF_FFFC);
        ref_dec(32'h0000_006F | (32'h1 << 31), mi, mf, mu);
        chk("model_jal_min", mi, 64'hFFFF_FFFF_FFF0_0000);

        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready64, 1'b1);
        chk("rst_out_valid", out_valid64, 1'b0);
        chk("rst_out", out64, 64'h0);
        @(negedge clk);
        rst = 1'b0;

        send_one(32'hFF813083, 64'hFFFF_FFFF_FFFF_FFF8, 3'd1, 1'b0, 32'hFFFF_FFF8);
        send_one(32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b0, 32'hFFFF_FFFC);
        send_one(32'h800002B7, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0, 32'h8000_0000);
        send_one(32'h00000033, 64'h0, 3'd0, 1'b1, 32'h0);

        // Fill to full with out_ready low, then drain in order.
        @(negedge clk);
        in_valid = 1'b1; in_w = 32'h00500093; out_ready = 1'b0;
        @(negedge clk);
        chk("fill_ready1", in_ready64, 1'b1);
        in_w = 32'h00A12423;
        @(negedge clk);
        chk("full_ready_a", in_ready64, 1'b0);
        chk("full_head_a", out64, 64'd5);
        in_w = 32'h12345037;
        @(negedge clk);
        chk("full_ready_b", in_ready64, 1'b0);
        chk("full_head_b", out64, 64'd5);
        @(negedge clk);
        chk("full_ready_c", in_ready64, 1'b0);
        chk("full_head_c", out64, 64'd5);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("ready_after_pop", in_ready64, 1'b1);
        chk("second_head", out64, 64'd8);
        chk("second_fmt", fmt64, 3'd2);
        @(negedge clk);
        chk("drained", out_valid64, 1'b0);
        out_ready = 1'b0;

        // Reset with two entries buffered.
        in_valid = 1'b1; in_w = 32'h00500093;
        @(negedge clk);
        in_w = 32'h00A12423;
        @(negedge clk);
        in_valid = 1'b0;
        chk("pre_rst_full", in_ready64, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("rst_now_out_valid", out_valid64, 1'b0);
        chk("rst_now_in_ready", in_ready64, 1'b1);
        chk("rst_now_out", out64, 64'h0);
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_no_stale", out_valid64, 1'b0);
        end
        out_ready = 1'b0;

        repeat (3) send_one(32'h00000033, 64'h0, 3'd0, 1'b1, 32'h0);
`ifdef IMM_GEN_STATS_EN
        chk("unknown_cnt_3", ucnt64, 16'd3);
`endif

        // Random accept/pop stream.
        start_pops = n_pops;
        cyc = 0;
        while ((n_pops - start_pops) < 10000 && cyc < 40000) begin
            @(negedge clk);
            w = $urandom;
            r = $urandom_range(0, 10);
            if (r < 10) w[6:0] = ops[r];
            in_w      = w;
            in_valid  = ($urandom_range(0, 99) < 70);
            out_ready = ($urandom_range(0, 99) < 70);
            cyc++;
        end
        chk("rand_transfers_done", (n_pops - start_pops) >= 10000, 1'b1);

`ifdef IMM_GEN_STATS_EN
        @(negedge clk);
        in_valid = 1'b1; in_w = 32'h00000033; out_ready = 1'b1;
        repeat (65540) @(negedge clk);
        chk("unknown_cnt_sat", ucnt64, 16'hFFFF);
`endif

        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("final_empty", out_valid64, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL provide parameter XLEN, default 64: output immediate width; legal values 32 and 64 only.
REQ-002 SHALL provide parameter DEPTH, default 2: output buffer entries; legal values 1..8.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 in_valid  input  1  instruction word valid.
REQ-007 in_ready  output  1  block can accept an instruction this cycle.
REQ-008 in  input  32  RISC-V instruction word.
REQ-009 out_valid  output  1  head entry valid.
REQ-010 out_ready  input  1  consumer takes the head entry this cycle.
REQ-011 out  output  XLEN  sign-extended immediate of the head entry.
REQ-012 fmt  output  3  head format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J; 6 and 7 are never driven.
REQ-013 unknown  output  1  head opcode is not in the REQ-016 table.

Function
REQ-014 Accept occurs when in_valid and in_ready are both high; pop occurs when out_valid and out_ready are both high.
REQ-015 Decode is combinational on in at accept time; result (out, fmt, unknown) is written into the DEPTH-entry FIFO.
REQ-016 Opcode in[6:0] to format:
- 0000011, 0010011, 0011011, 1100111 -> I, imm = in[31:20]
- 0100011 -> S, imm = {in[31:25], in[11:7]}
- 1100011 -> B, imm = {in[31], in[7], in[30:25], in[11:8], 1'b0}
- 0110111, 0010111 -> U, imm = {in[31:12], 12'b0}
- 1101111 -> J, imm = {in[31], in[19:12], in[20], in[30:21], 1'b0}
- any other opcode -> NONE, imm = 0, unknown = 1
REQ-017 The immediate SHALL be sign-extended from its MSB to 64 bits; out is bits [XLEN-1:0] of that value.
REQ-018 Latency: an instruction accepted at edge k into an empty FIFO SHALL appear with out_valid = 1 after edge k.
REQ-019 in_ready = (count < DEPTH); it is derived from registered count only and has no combinational path from out_ready.
REQ-020 Simultaneous accept and pop when not full: count is unchanged, order is preserved, and no entry is lost or duplicated.
REQ-021 When full, in_ready = 0 even if out_ready = 1 (no bypass); accept resumes the cycle after a pop.
REQ-022 out_valid = (count > 0); out, fmt and unknown SHALL hold stable while out_valid = 1 and out_ready = 0.
REQ-023 When empty, out = 0, fmt = 0 and unknown = 0.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH.

Reset
REQ-025 While rst = 1: count, pointers and all FIFO entries clear; in_ready = 1 (DEPTH >= 1); out_valid = 0; out = 0; fmt = 0; unknown = 0.
REQ-026 Reset asserted mid-transfer SHALL discard all buffered entries; no out_valid pulse follows deassertion until a new accept.

Configuration
REQ-027 Macro IMM_GEN_STATS_EN defined: SHALL add output port unknown_cnt [15:0].
- unknown_cnt increments on each accepted instruction with an unknown opcode.
- It saturates at 0xFFFF and is cleared by rst.
REQ-028 Macro IMM_GEN_STATS_EN undefined: port unknown_cnt and its counter SHALL be absent; all other behaviour is identical.

Verification
REQ-029 XLEN=64, in=0xFF813083 (ld) accepted into empty FIFO -> next cycle out_valid=1, out=0xFFFFFFFFFFFFFFF8, fmt=1, unknown=0.
REQ-030 in=0xFE000EE3 (beq, offset -4) -> out=0xFFFFFFFFFFFFFFFC, fmt=3; in=0x800002B7 (lui 0x80000) -> out=0xFFFFFFFF80000000, fmt=4; XLEN=32 same lui -> out=0x80000000.
REQ-031 DEPTH=2, in_valid held high with distinct words, out_ready=0 for 4 cycles:
- two accepts occur, then in_ready=0 and the head is stable;
- with out_ready=1, entries pop in order and in_ready=1 the cycle after the first pop.
REQ-032 in=0x00000033 (R-type) -> out=0, fmt=0, unknown=1; with IMM_GEN_STATS_EN, 3 such accepts give unknown_cnt=3, and the counter holds at 0xFFFF after 65536+ accepts.
REQ-033 rst pulsed with 2 entries buffered -> out_valid=0 and in_ready=1 immediately, with no stale output after release.
REQ-034 Random accept/pop streams against a reference decoder model -> zero mismatches over 10,000 transfers, and count never exceeds DEPTH.
